regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-port register file with byte-enabled writes and async reset clear.
//  Defines priority between write ports that hit the same entry; optional hardwired-zero entry 0.
//  Adds a per-entry busy scoreboard and a per-read-port hold control.
//  Sits in the scalar unit between decode (reads, allocation) and writeback (writes, busy clear).
// PARAMETERS
//  IDX_WIDTH     4                 index width
//  DATA_WIDTH    32                entry width in bits; multiple of 8
//  DEPTH         1<<IDX_WIDTH      number of entries; DEPTH <= 2**IDX_WIDTH
//  NUM_RD_PORTS  3                 read ports
//  NUM_WR_PORTS  3                 write ports
//  ZERO_REG      0                 1: entry 0 reads 0, ignores writes, never busy
// PORTS
//  clk         in   1                              clock, all state updates on rising edge
//  rst_n       in   1                              async active-low reset
//  wr_idx      in   [IDX_WIDTH-1:0] x NUM_WR_PORTS   write index
//  wr_data     in   [DATA_WIDTH-1:0] x NUM_WR_PORTS  write data
//  byte_en     in   [DATA_WIDTH/8-1:0] x NUM_WR_PORTS byte enables; all-zero = no write
//  wr_clr      in   [NUM_WR_PORTS-1:0]             clear busy bit of wr_idx[i]
//  alloc_en    in   1                              set busy bit of alloc_idx
//  alloc_idx   in   [IDX_WIDTH-1:0]                entry to mark busy
//  rd_en       in   [NUM_RD_PORTS-1:0]             1: capture rd_idx[i]; 0: hold captured index
//  rd_idx      in   [IDX_WIDTH-1:0] x NUM_RD_PORTS   read index
//  rd_data     out  [DATA_WIDTH-1:0] x NUM_RD_PORTS  read data
//  rd_busy     out  [NUM_RD_PORTS-1:0]             busy bit of the captured read index
//  busy_vec    out  [DEPTH-1:0]                    full scoreboard, registered
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//  - All entries, all busy bits and all captured read indices go to 0.
//  - Hence rd_data=0, rd_busy=0 and busy_vec=0 during reset and in the first cycle after release.
//  Write:
//  - For each port i and each byte j with byte_en[i][j]=1, byte j of entry wr_idx[i] takes wr_data[i] byte j at the edge.
//  - Same entry and same byte from several ports: the highest-numbered port wins.
//  - Disjoint bytes of one entry from different ports merge.
//  - wr_idx >= DEPTH: the write is dropped.
//  Read:
//  - At an edge with rd_en[i]=1, rd_idx[i] is captured into rd_idx_q[i].
//  - rd_data[i] is combinational from mem[rd_idx_q[i]].
//  - One-cycle read latency, write-first: a write at the same edge as the index capture is visible in the next cycle.
//  - While rd_en[i]=0, rd_data[i] tracks later writes to the held index.
//  - rd_idx_q >= DEPTH: rd_data=0 and rd_busy=0.
//  Scoreboard busy[DEPTH]:
//  - busy[alloc_idx] is set at the edge when alloc_en=1.
//  - busy[wr_idx[i]] is cleared at the edge when wr_clr[i]=1, independent of byte_en.
//  - Set and clear of the same entry at the same edge: set wins, because the new allocation supersedes the old writeback.
//  - rd_busy[i] = busy[rd_idx_q[i]], using the post-edge value, which is consistent with rd_data.
//  ZERO_REG=1:
//  - Writes, clears and allocs to entry 0 are ignored.
//  - rd_data is 0 and rd_busy is 0 for index 0.
//  No other state and no stall outputs; all ports are always accepted.
// TESTING
//  Reset: assert rst_n=0 mid-stream after writes -> rd_data=0, busy_vec=0 immediately; after release, read of any idx returns 0.
//  Byte merge and priority: port0 writes idx5 0x11223344 be=4'b1111 and port2 writes idx5 0xAABBCCDD be=4'b0011 at the same edge
//    -> next-cycle read of idx5 = 0x1122CCDD.
//  Write-first and hold: write idx3 0xDEADBEEF with rd_idx=3, rd_en=1 at the same edge -> rd_data=0xDEADBEEF next cycle.
//    Then rd_en=0, write idx3 0x1 -> rd_data=0x1.
//  Scoreboard: alloc idx7 -> rd_busy=1 and busy_vec[7]=1.
//    wr_clr on idx7 together with alloc_en on idx7 -> busy stays 1.
//    Then wr_clr alone -> busy=0.
//  ZERO_REG=1: write idx0 0xFFFFFFFF plus alloc idx0 -> rd_data=0, rd_busy=0, busy_vec[0]=0.
//  Random: all ports random for 10k cycles, compared against a reference model with port priority and set-wins rules.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bundle of write, scoreboard and read signals between the register file and its
// decode/writeback neighbours.
interface regfile_sb_if #(
   parameter int IDX_WIDTH    = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 1 << IDX_WIDTH,
   parameter int NUM_RD_PORTS = 3,
   parameter int NUM_WR_PORTS = 3
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [NUM_WR_PORTS-1:0][IDX_WIDTH-1:0]  wr_idx;
   logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;
   logic [NUM_WR_PORTS-1:0][BE_WIDTH-1:0]   byte_en;
   logic [NUM_WR_PORTS-1:0]                 wr_clr;
   logic                                    alloc_en;
   logic [IDX_WIDTH-1:0]                    alloc_idx;
   logic [NUM_RD_PORTS-1:0]                 rd_en;
   logic [NUM_RD_PORTS-1:0][IDX_WIDTH-1:0]  rd_idx;
   logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;
   logic [NUM_RD_PORTS-1:0]                 rd_busy;
   logic [DEPTH-1:0]                        busy_vec;

   modport master (
      output wr_idx, wr_data, byte_en, wr_clr, alloc_en, alloc_idx, rd_en, rd_idx,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  wr_idx, wr_data, byte_en, wr_clr, alloc_en, alloc_idx, rd_en, rd_idx,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with byte-enabled writes, highest-port-wins priority,
// optional hardwired-zero entry 0, busy scoreboard and per-read-port index hold.
module regfile_sb #(
   parameter int IDX_WIDTH    = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 1 << IDX_WIDTH,
   parameter int NUM_RD_PORTS = 3,
   parameter int NUM_WR_PORTS = 3,
   parameter bit ZERO_REG     = 1'b0
) (
   input logic          clk,
   input logic          rst_n,
   regfile_sb_if.slave  bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]      busy_q;
   logic [DEPTH-1:0]      busy_d;
   logic [IDX_WIDTH-1:0]  rd_idx_q [NUM_RD_PORTS];
   logic [IDX_WIDTH-1:0]  rd_idx_d [NUM_RD_PORTS];

   function automatic logic in_range(input logic [IDX_WIDTH-1:0] idx);
      return int'({1'b0, idx}) < DEPTH;
   endfunction

   // Entry 0 is excluded from all state changes when it is hardwired to zero.
   function automatic logic is_live(input logic [IDX_WIDTH-1:0] idx);
      return in_range(idx) && !(ZERO_REG && (idx == IDX_WIDTH'(0)));
   endfunction

   // Next-state for storage, scoreboard and captured read indices.
   always_comb begin
      mem_d  = mem_q;
      busy_d = busy_q;
      // Ascending port order lets the highest-numbered port win on byte overlap.
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (bus.byte_en[p][b] && is_live(bus.wr_idx[p])) begin
               mem_d[bus.wr_idx[p]][b*8 +: 8] = bus.wr_data[p][b*8 +: 8];
            end else begin
               mem_d[0] = mem_d[0];
            end
         end
         if (bus.wr_clr[p] && is_live(bus.wr_idx[p])) begin
            busy_d[bus.wr_idx[p]] = 1'b0;
         end else begin
            busy_d = busy_d;
         end
      end
      // Allocation is applied after clears so a new owner supersedes a retiring one.
      if (bus.alloc_en && is_live(bus.alloc_idx)) begin
         busy_d[bus.alloc_idx] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         if (bus.rd_en[r]) begin
            rd_idx_d[r] = bus.rd_idx[r];
         end else begin
            rd_idx_d[r] = rd_idx_q[r];
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            mem_q[e] <= '0;
         end
         busy_q <= '0;
         for (int r = 0; r < NUM_RD_PORTS; r++) begin
            rd_idx_q[r] <= '0;
         end
      end else begin
         mem_q    <= mem_d;
         busy_q   <= busy_d;
         rd_idx_q <= rd_idx_d;
      end
   end

   // Read data and busy follow the captured index, so held ports see later writes.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int r = 0; r < NUM_RD_PORTS; r++) begin
         if (is_live(rd_idx_q[r])) begin
            bus.rd_data[r] = mem_q[rd_idx_q[r]];
            bus.rd_busy[r] = busy_q[rd_idx_q[r]];
         end else begin
            bus.rd_data[r] = '0;
            bus.rd_busy[r] = 1'b0;
         end
      end
   end

   assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and model-based checks for regfile_sb; a second instance covers the
// hardwired-zero entry and a depth smaller than the index range.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_sb_if #(.IDX_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16)) m_if ();
   regfile_sb_if #(.IDX_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12)) z_if ();

   regfile_sb #(.IDX_WIDTH(4), .DATA_WIDTH(32), .DEPTH(16), .ZERO_REG(1'b0))
      dut (.clk(clk), .rst_n(rst_n), .bus(m_if));

   regfile_sb #(.IDX_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12), .ZERO_REG(1'b1))
      dut_z (.clk(clk), .rst_n(rst_n), .bus(z_if));

   task automatic idle();
      m_if.wr_idx = '0; m_if.wr_data = '0; m_if.byte_en = '0; m_if.wr_clr = '0;
      m_if.alloc_en = 1'b0; m_if.alloc_idx = '0; m_if.rd_en = '0; m_if.rd_idx = '0;
      z_if.wr_idx = '0; z_if.wr_data = '0; z_if.byte_en = '0; z_if.wr_clr = '0;
      z_if.alloc_en = 1'b0; z_if.alloc_idx = '0; z_if.rd_en = '0; z_if.rd_idx = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      cyc(); cyc();
      n_checks++;
      if (m_if.rd_data !== 96'h0 || m_if.busy_vec !== 16'h0 || m_if.rd_busy !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_hold: rd_data=%h busy_vec=%h rd_busy=%b, want all 0",
                  m_if.rd_data, m_if.busy_vec, m_if.rd_busy);
      end
      rst_n = 1'b1;
      cyc();
      n_checks++;
      if (m_if.rd_data !== 96'h0 || m_if.busy_vec !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_release: rd_data=%h busy_vec=%h, want 0", m_if.rd_data, m_if.busy_vec);
      end
      m_if.wr_idx[0] = 4'd5; m_if.wr_data[0] = 32'hFFFF_FFFF; m_if.byte_en[0] = 4'hF;
      m_if.alloc_en = 1'b1; m_if.alloc_idx = 4'd5;
      m_if.rd_en[0] = 1'b1; m_if.rd_idx[0] = 4'd5;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[0] !== 32'hFFFF_FFFF || m_if.busy_vec !== 16'h0020) begin
         n_fail++;
         $display("FAIL reset_prewrite: rd_data=%h busy_vec=%h, want ffffffff 0020",
                  m_if.rd_data[0], m_if.busy_vec);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_if.rd_data !== 96'h0 || m_if.busy_vec !== 16'h0 || m_if.rd_busy !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_async: rd_data=%h busy_vec=%h rd_busy=%b, want 0",
                  m_if.rd_data, m_if.busy_vec, m_if.rd_busy);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_if.rd_en[0] = 1'b1; m_if.rd_idx[0] = 4'd5;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cleared_entry: rd_data=%h, want 0", m_if.rd_data[0]);
      end
   endtask

   task automatic test_byte_merge();
      idle();
      m_if.wr_idx[0] = 4'd5; m_if.wr_data[0] = 32'h1122_3344; m_if.byte_en[0] = 4'b1111;
      m_if.wr_idx[2] = 4'd5; m_if.wr_data[2] = 32'hAABB_CCDD; m_if.byte_en[2] = 4'b0011;
      m_if.rd_en[0] = 1'b1; m_if.rd_idx[0] = 4'd5;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[0] !== 32'h1122_CCDD) begin
         n_fail++;
         $display("FAIL byte_merge: got %h, want 1122ccdd", m_if.rd_data[0]);
      end
      m_if.wr_idx[0] = 4'd6; m_if.wr_data[0] = 32'h0000_00AA; m_if.byte_en[0] = 4'b0001;
      m_if.wr_idx[1] = 4'd6; m_if.wr_data[1] = 32'h0000_00BB; m_if.byte_en[1] = 4'b0001;
      m_if.wr_idx[2] = 4'd6; m_if.wr_data[2] = 32'h0077_0000; m_if.byte_en[2] = 4'b0100;
      m_if.rd_en[1] = 1'b1; m_if.rd_idx[1] = 4'd6;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[1] !== 32'h0077_00BB) begin
         n_fail++;
         $display("FAIL port_priority: got %h, want 007700bb", m_if.rd_data[1]);
      end
   endtask

   task automatic test_write_first_hold();
      idle();
      m_if.wr_idx[1] = 4'd3; m_if.wr_data[1] = 32'hDEAD_BEEF; m_if.byte_en[1] = 4'hF;
      m_if.rd_en[1] = 1'b1; m_if.rd_idx[1] = 4'd3;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[1] !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL write_first: got %h, want deadbeef", m_if.rd_data[1]);
      end
      m_if.rd_idx[1] = 4'd5;
      m_if.wr_idx[0] = 4'd3; m_if.wr_data[0] = 32'h0000_0001; m_if.byte_en[0] = 4'hF;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_data[1] !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL hold_tracks_write: got %h, want 00000001", m_if.rd_data[1]);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      m_if.alloc_en = 1'b1; m_if.alloc_idx = 4'd7;
      m_if.rd_en[2] = 1'b1; m_if.rd_idx[2] = 4'd7;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_busy[2] !== 1'b1 || m_if.busy_vec !== 16'h0080) begin
         n_fail++;
         $display("FAIL sb_alloc: rd_busy=%b busy_vec=%h, want 1 0080", m_if.rd_busy[2], m_if.busy_vec);
      end
      m_if.wr_clr[0] = 1'b1; m_if.wr_idx[0] = 4'd7;
      m_if.alloc_en = 1'b1; m_if.alloc_idx = 4'd7;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_busy[2] !== 1'b1 || m_if.busy_vec !== 16'h0080) begin
         n_fail++;
         $display("FAIL sb_set_wins: rd_busy=%b busy_vec=%h, want 1 0080", m_if.rd_busy[2], m_if.busy_vec);
      end
      m_if.wr_clr[2] = 1'b1; m_if.wr_idx[2] = 4'd7;
      cyc();
      idle();
      n_checks++;
      if (m_if.rd_busy[2] !== 1'b0 || m_if.busy_vec !== 16'h0000) begin
         n_fail++;
         $display("FAIL sb_clear: rd_busy=%b busy_vec=%h, want 0 0000", m_if.rd_busy[2], m_if.busy_vec);
      end
   endtask

   task automatic test_zero_reg();
      idle();
      z_if.wr_idx[0] = 4'd0; z_if.wr_data[0] = 32'hFFFF_FFFF; z_if.byte_en[0] = 4'hF;
      z_if.alloc_en = 1'b1; z_if.alloc_idx = 4'd0;
      z_if.rd_en[0] = 1'b1; z_if.rd_idx[0] = 4'd0;
      cyc();
      idle();
      n_checks++;
      if (z_if.rd_data[0] !== 32'h0 || z_if.rd_busy[0] !== 1'b0 || z_if.busy_vec !== 12'h000) begin
         n_fail++;
         $display("FAIL zero_reg: rd_data=%h rd_busy=%b busy_vec=%h, want 0",
                  z_if.rd_data[0], z_if.rd_busy[0], z_if.busy_vec);
      end
      z_if.wr_idx[1] = 4'd13; z_if.wr_data[1] = 32'hCAFE_F00D; z_if.byte_en[1] = 4'hF;
      z_if.alloc_en = 1'b1; z_if.alloc_idx = 4'd13;
      z_if.rd_en[1] = 1'b1; z_if.rd_idx[1] = 4'd13;
      cyc();
      idle();
      n_checks++;
      if (z_if.rd_data[1] !== 32'h0 || z_if.rd_busy[1] !== 1'b0 || z_if.busy_vec !== 12'h000) begin
         n_fail++;
         $display("FAIL out_of_range: rd_data=%h rd_busy=%b busy_vec=%h, want 0",
                  z_if.rd_data[1], z_if.rd_busy[1], z_if.busy_vec);
      end
      z_if.wr_idx[2] = 4'd11; z_if.wr_data[2] = 32'h1234_5678; z_if.byte_en[2] = 4'hF;
      z_if.alloc_en = 1'b1; z_if.alloc_idx = 4'd11;
      z_if.rd_en[2] = 1'b1; z_if.rd_idx[2] = 4'd11;
      cyc();
      idle();
      n_checks++;
      if (z_if.rd_data[2] !== 32'h1234_5678 || z_if.rd_busy[2] !== 1'b1 || z_if.busy_vec !== 12'h800) begin
         n_fail++;
         $display("FAIL last_entry: rd_data=%h rd_busy=%b busy_vec=%h, want 12345678 1 800",
                  z_if.rd_data[2], z_if.rd_busy[2], z_if.busy_vec);
      end
   endtask

   task automatic test_random();
      logic [31:0] m_mem [16];
      logic [15:0] m_busy;
      logic [3:0]  m_rq [3];
      logic [31:0] exp_d;
      logic        exp_b;
      idle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int e = 0; e < 16; e++) m_mem[e] = 32'h0;
      m_busy = 16'h0;
      for (int r = 0; r < 3; r++) m_rq[r] = 4'd0;
      for (int c = 0; c < 10000; c++) begin
         for (int p = 0; p < 3; p++) begin
            m_if.wr_idx[p]  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            m_if.wr_data[p] = $urandom;
            m_if.byte_en[p] = 4'($urandom_range(0, 15));
            m_if.wr_clr[p]  = ($urandom_range(0, 3) == 0);
         end
         m_if.alloc_en  = ($urandom_range(0, 2) == 0);
         m_if.alloc_idx = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         for (int r = 0; r < 3; r++) begin
            m_if.rd_en[r]  = ($urandom_range(0, 1) == 0);
            m_if.rd_idx[r] = 4'($urandom_range(0, 15));
         end
         for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
               if (m_if.byte_en[p][b]) m_mem[m_if.wr_idx[p]][b*8 +: 8] = m_if.wr_data[p][b*8 +: 8];
            end
            if (m_if.wr_clr[p]) m_busy[m_if.wr_idx[p]] = 1'b0;
         end
         if (m_if.alloc_en) m_busy[m_if.alloc_idx] = 1'b1;
         for (int r = 0; r < 3; r++) begin
            if (m_if.rd_en[r]) m_rq[r] = m_if.rd_idx[r];
         end
         cyc();
         for (int r = 0; r < 3; r++) begin
            exp_d = m_mem[m_rq[r]];
            exp_b = m_busy[m_rq[r]];
            n_checks++;
            if (m_if.rd_data[r] !== exp_d || m_if.rd_busy[r] !== exp_b) begin
               n_fail++;
               if (n_fail < 20)
                  $display("FAIL random_rd%0d cycle %0d: got %h/%b, want %h/%b",
                           r, c, m_if.rd_data[r], m_if.rd_busy[r], exp_d, exp_b);
            end
         end
         n_checks++;
         if (m_if.busy_vec !== m_busy) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL random_busy_vec cycle %0d: got %h, want %h", c, m_if.busy_vec, m_busy);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_byte_merge();
      test_write_first_hold();
      test_scoreboard();
      test_zero_reg();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
